// File: rtl/life_if.sv
// Host-side bundle for life_array: load/step requests, rule masks, readback and status.
// step and load_en are accepted only while busy=0; while busy they are dropped, never queued.
interface life_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int GENW = 16
);
    localparam int RW = $clog2(ROWS);

    logic            load_en;
    logic [RW-1:0]   load_row;
    logic [COLS-1:0] load_data;
    logic            step;
    logic [8:0]      birth_mask;
    logic [8:0]      survive_mask;
    logic [RW-1:0]   rd_row;
    logic [COLS-1:0] rd_data;
    logic            busy;
    logic            done;
    logic [GENW-1:0] gen_count;

    modport master (
        output load_en, load_row, load_data, step, birth_mask, survive_mask, rd_row,
        input  rd_data, busy, done, gen_count
    );

    modport slave (
        input  load_en, load_row, load_data, step, birth_mask, survive_mask, rd_row,
        output rd_data, busy, done, gen_count
    );
endinterface

// File: rtl/life_array.sv
// Game-of-Life grid engine: double-buffered ROWS x COLS array, one row per clock,
// runtime birth/survive masks, torus or dead-edge boundaries, generation counter.
module life_array #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int WRAP = 1,
    parameter int GENW = 16
) (
    input  logic       clk,
    input  logic       rst,
    life_if.slave      bus,
    output logic [1:0] dbg_state_o
);
    localparam int RW = $clog2(ROWS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [COLS-1:0] grid_q [ROWS];
    logic [COLS-1:0] nxt_q  [ROWS];
    logic [RW-1:0]   r_q;
    logic [8:0]      birth_q, survive_q;
    logic [GENW-1:0] gen_q;
    logic            done_q;

    logic [RW-1:0]   up_idx, dn_idx;
    logic            up_ok, dn_ok;
    logic [COLS+1:0] ext_up, ext_mid, ext_dn;
    logic [COLS-1:0] row_next;
    logic [3:0]      ncnt [COLS];

    // Pads a row with one neighbour column on each side: wrapped or dead.
    function automatic logic [COLS+1:0] pad_row(input logic [COLS-1:0] row);
        logic hi, lo;
        hi = (WRAP != 0) ? row[0] : 1'b0;
        lo = (WRAP != 0) ? row[COLS-1] : 1'b0;
        return {hi, row, lo};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!bus.load_en && bus.step) state_d = S_CALC;
            S_CALC:   if (r_q == RW'(ROWS - 1)) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state_q == S_CALC) || (state_q == S_COMMIT);
        dbg_state_o = state_q;
    end

    always_comb begin
        up_ok   = (r_q != '0) || (WRAP != 0);
        dn_ok   = (r_q != RW'(ROWS - 1)) || (WRAP != 0);
        up_idx  = (r_q == '0) ? RW'(ROWS - 1) : r_q - RW'(1);
        dn_idx  = (r_q == RW'(ROWS - 1)) ? '0 : r_q + RW'(1);
        ext_up  = up_ok ? pad_row(grid_q[up_idx]) : '0;
        ext_mid = pad_row(grid_q[r_q]);
        ext_dn  = dn_ok ? pad_row(grid_q[dn_idx]) : '0;
    end

    // ext_*[c+1] is column c, so column c's neighbours sit at ext_*[c], ext_*[c+2].
    always_comb begin
        row_next = '0;
        for (int c = 0; c < COLS; c++) begin
            ncnt[c] = 4'(ext_up[c]) + 4'(ext_up[c+1]) + 4'(ext_up[c+2])
                    + 4'(ext_mid[c]) + 4'(ext_mid[c+2])
                    + 4'(ext_dn[c]) + 4'(ext_dn[c+1]) + 4'(ext_dn[c+2]);
            row_next[c] = ext_mid[c+1] ? survive_q[ncnt[c]] : birth_q[ncnt[c]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                grid_q[r] <= '0;
                nxt_q[r]  <= '0;
            end
            r_q       <= '0;
            birth_q   <= '0;
            survive_q <= '0;
            gen_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.load_en) begin
                        if (int'(bus.load_row) < ROWS) grid_q[bus.load_row] <= bus.load_data;
                    end else if (bus.step) begin
                        birth_q   <= bus.birth_mask;
                        survive_q <= bus.survive_mask;
                        r_q       <= '0;
                    end
                end
                S_CALC: begin
                    nxt_q[r_q] <= row_next;
                    r_q        <= r_q + RW'(1);
                end
                S_COMMIT: begin
                    for (int r = 0; r < ROWS; r++) grid_q[r] <= nxt_q[r];
                    gen_q  <= gen_q + GENW'(1);
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.rd_data = '0;
        if (int'(bus.rd_row) < ROWS) bus.rd_data = grid_q[bus.rd_row];
    end

    assign bus.done      = done_q;
    assign bus.gen_count = gen_q;
endmodule
